// File: rtl/nes_pkg.sv
// Shared NES top-level definitions: sprite-DMA state encoding and default bus addresses.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA bus master: a write to TRIG_ADDR halts the CPU and copies LEN bytes
// from page {page,00h} to DEST_ADDR, one get/put M-cycle pair per byte.
module oam_dma
    import nes_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] TRIG_ADDR = ADDR_W'(OAMDMA_ADDR),
    parameter logic [ADDR_W-1:0] DEST_ADDR = ADDR_W'(OAMDATA_ADDR),
    parameter int                LEN       = 256
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_ce,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] dma_rdata,
    output logic              rdy,
    output logic              dma_active,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_wdata,
    output logic              dma_rw,
    output logic              done
);

    localparam int         PAGE_W     = ADDR_W - 8;
    localparam logic [7:0] LAST_INDEX = 8'(LEN - 1);

    dma_state_t        state;
    dma_state_t        state_next;
    logic              parity;
    logic [7:0]        index;
    logic [PAGE_W-1:0] page;
    logic [DATA_W-1:0] buffer;
    logic              trigger;
    logic              last_byte;
    logic [ADDR_W-1:0] read_addr;

    assign trigger   = !cpu_rw && (cpu_addr == TRIG_ADDR);
    assign last_byte = (index == LAST_INDEX);
    assign read_addr = {page, 8'h00} + ADDR_W'(index);
    assign dma_wdata = buffer;

    // Every transition is qualified by cpu_ce; between enables the FSM holds.
    always_comb begin
        state_next = state;
        if (cpu_ce) begin
            case (state)
                IDLE:    if (trigger) state_next = HALT;
                HALT:    state_next = parity ? READ : ALIGN;
                ALIGN:   state_next = READ;
                READ:    state_next = WRITE;
                WRITE:   state_next = last_byte ? IDLE : READ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rdy        = 1'b1;
        dma_active = 1'b0;
        dma_rw     = 1'b1;
        dma_addr   = '0;
        case (state)
            HALT, ALIGN: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
                dma_addr   = cpu_addr;
            end
            READ: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
                dma_addr   = read_addr;
            end
            WRITE: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
                dma_rw     = 1'b0;
                dma_addr   = DEST_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state  <= IDLE;
            parity <= 1'b0;
            index  <= '0;
            page   <= '0;
            buffer <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cpu_ce) begin
                state  <= state_next;
                parity <= ~parity;
                if (state == IDLE && trigger) begin
                    page  <= PAGE_W'(cpu_wdata);
                    index <= '0;
                end
                if (state == READ) buffer <= dma_rdata;
                if (state == WRITE) begin
                    index <= index + 8'd1;
                    done  <= last_byte;
                end
            end
        end
    end

endmodule
